// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter. It defines:
//   state_t   : the arbiter FSM states (IDLE, SERVE, RESP).
//   port_id_t : the 1-bit master identifier.
//   PORT_CORE : the core load/store unit (port 0).
//   PORT_AUX  : the debug/loader master (port 1).
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_CORE = 1'b0;
    localparam port_id_t PORT_AUX  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// This is a combinational two-way round-robin grant selector.
// Ports:
//   req0, req1  : the requests that are eligible this cycle.
//   last_grant  : the port that won the previous arbitration.
//   grant_valid : high when either request is high.
//   grant_id    : the winning port. When both ports request, the port that
//                 did not win last time gets the grant.
// ---------------------------------------------------------------------------
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  port_id_t last_grant,
    output logic     grant_valid,
    output port_id_t grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = PORT_AUX;
        end else begin
            grant_id = PORT_CORE;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// This module shares one single-port data memory between the core LSU
// (port 0) and a secondary master (port 1). Each access passes through
// three states: IDLE, then SERVE, then RESP.
//
// Handshake: a master raises reqN. It holds reqN, weN, addrN and wdataN
// stable until ackN pulses for one cycle. rdataN and errN are valid while
// ackN is high. They keep their value until that port's next SERVE.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset.
//   req*/we*/addr*/wdata* : master request side.
//   ack*/rdata*/err*  : master response side. All are registered.
//   mem_*             : memory pins. They are driven only in SERVE and are
//                       zero otherwise. mem_read_data is combinational.
//   dbg_state_o       : the current FSM state, for observation.
// ---------------------------------------------------------------------------
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int Bits    = 64,
    parameter int MemSize = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [Bits-1:0] addr0,
    input  logic [Bits-1:0] addr1,
    input  logic [Bits-1:0] wdata0,
    input  logic [Bits-1:0] wdata1,
    output logic            ack0,
    output logic            ack1,
    output logic [Bits-1:0] rdata0,
    output logic [Bits-1:0] rdata1,
    output logic            err0,
    output logic            err1,
    output logic [Bits-1:0] mem_access_addr,
    output logic [Bits-1:0] mem_write_data,
    output logic            mem_write_en,
    output logic            mem_read,
    input  logic [Bits-1:0] mem_read_data,
    output state_t          dbg_state_o
);

    localparam logic [Bits-1:0] MEM_LIMIT = Bits'(MemSize);

    state_t          state_q;
    port_id_t        owner_q;
    port_id_t        last_grant_q;
    logic            ack0_q, ack1_q;
    logic            err0_q, err1_q;
    logic [Bits-1:0] rdata0_q, rdata1_q;

    // In RESP, the port that is completing may not compete. This stops it
    // from winning again straight away when the other port is idle.
    logic     arb_req0, arb_req1;
    logic     grant_valid;
    port_id_t grant_id;

    assign arb_req0 = req0 & ~((state_q == RESP) && (owner_q == PORT_CORE));
    assign arb_req1 = req1 & ~((state_q == RESP) && (owner_q == PORT_AUX));

    rr_arbiter2 u_arb (
        .req0        (arb_req0),
        .req1        (arb_req1),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Select the owner's request fields.
    logic            sel_we;
    logic [Bits-1:0] sel_addr, sel_wdata, sel_rdata;
    logic            in_range, serving;

    assign serving   = (state_q == SERVE);
    assign sel_we    = (owner_q == PORT_AUX) ? we1    : we0;
    assign sel_addr  = (owner_q == PORT_AUX) ? addr1  : addr0;
    assign sel_wdata = (owner_q == PORT_AUX) ? wdata1 : wdata0;
    // Compare at full width so that high address bits cannot alias into range.
    assign in_range  = (sel_addr < MEM_LIMIT);
    // Writes and out-of-range accesses return zero.
    assign sel_rdata = (in_range && !sel_we) ? mem_read_data : '0;

    assign mem_access_addr = serving ? sel_addr  : '0;
    assign mem_write_data  = serving ? sel_wdata : '0;
    assign mem_write_en    = serving & sel_we  & in_range;
    assign mem_read        = serving & ~sel_we & in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= PORT_CORE;
            last_grant_q <= PORT_AUX;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (grant_valid) begin
                        state_q      <= SERVE;
                        owner_q      <= grant_id;
                        last_grant_q <= grant_id;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SERVE: begin
                    state_q <= RESP;
                    if (owner_q == PORT_CORE) begin
                        rdata0_q <= sel_rdata;
                        err0_q   <= ~in_range;
                        ack0_q   <= 1'b1;
                    end else begin
                        rdata1_q <= sel_rdata;
                        err1_q   <= ~in_range;
                        ack1_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign err0        = err0_q;
    assign err1        = err1_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// This is a directed bench for data_mem_arbiter with a behavioural
// 256-word memory. Inputs are driven 1ns after posedge. Outputs are
// sampled on negedge.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [63:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [63:0] rdata0, rdata1;
    logic [63:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read;
    state_t      dut_state;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    data_mem_arbiter #(.Bits(64), .MemSize(256)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0            (req0),
        .req1            (req1),
        .we0             (we0),
        .we1             (we1),
        .addr0           (addr0),
        .addr1           (addr1),
        .wdata0          (wdata0),
        .wdata1          (wdata1),
        .ack0            (ack0),
        .ack1            (ack1),
        .rdata0          (rdata0),
        .rdata1          (rdata1),
        .err0            (err0),
        .err1            (err1),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data),
        .dbg_state_o     (dut_state)
    );

    // ---------------- memory model ----------------
    // The model decodes only the low 8 bits. A stray out-of-range write
    // would therefore corrupt a real word, and a later read would show it.
    logic        preload_en;
    logic [7:0]  preload_addr;
    logic [63:0] preload_data;
    logic [63:0] mem [256];

    always @(posedge clk) begin
        if (preload_en) mem[preload_addr] <= preload_data;
        else if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_access_addr[7:0]];

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        @(posedge clk); #1;
        preload_en   = 1'b0;
    endtask

    // This task starts with the arbiter in IDLE, 1ns after a posedge. It
    // issues one access, waits for the ack within a bounded number of
    // cycles, and returns with the arbiter back in IDLE.
    task automatic access(input bit p, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] exp_rd,
                          input logic exp_err, input string tag);
        logic in_r;
        int   n_we, n_rd, cyc;
        bit   got;
        in_r = (a < 64'd256);
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        n_we = 0; n_rd = 0; cyc = 0; got = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            if (mem_write_en) n_we++;
            if (mem_read) n_rd++;
            if (cyc == 1) begin
                check_eq({tag, "_maddr"}, mem_access_addr, a);
                check_eq({tag, "_mwdata"}, mem_write_data, d);
            end
            if (p ? ack1 : ack0) begin
                got = 1'b1;
                check_eq({tag, "_latency"}, 64'(cyc), 64'd2);
                check_eq({tag, "_other_ack"}, {63'd0, p ? ack0 : ack1}, 64'd0);
                check_eq({tag, "_rdata"}, p ? rdata1 : rdata0, exp_rd);
                check_eq({tag, "_err"}, {63'd0, p ? err1 : err0}, {63'd0, exp_err});
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!got) check_eq({tag, "_ack_timeout"}, 64'd0, 64'd1);
        check_eq({tag, "_we_cycles"}, 64'(n_we), {63'd0, w & in_r});
        check_eq({tag, "_rd_cycles"}, 64'(n_rd), {63'd0, ~w & in_r});
        if (p) req1 = 1'b0; else req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        preload_en = 1'b0; preload_addr = '0; preload_data = '0;
        // Both ports request reads continuously, starting from reset.
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'd5; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'd7; wdata1 = '0;
        @(posedge clk); #1;
        preload(8'd0,   64'h0A0A);
        preload(8'd5,   64'hDEAD_BEEF);
        preload(8'd7,   64'hCAFE);
        preload(8'd255, 64'h55);

        // Check the reset state while rst is still high.
        @(negedge clk);
        check_eq("rst_ack0",  {63'd0, ack0}, 64'd0);
        check_eq("rst_ack1",  {63'd0, ack1}, 64'd0);
        check_eq("rst_err",   {62'd0, err0, err1}, 64'd0);
        check_eq("rst_rdata0", rdata0, 64'd0);
        check_eq("rst_rdata1", rdata1, 64'd0);
        check_eq("rst_maddr", mem_access_addr, 64'd0);
        check_eq("rst_mwdata", mem_write_data, 64'd0);
        check_eq("rst_mctl",  {62'd0, mem_write_en, mem_read}, 64'd0);
        check_eq("rst_state", 64'(dut_state), 64'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention: grants must go 0, 1, 0, 1, with acks at T+2, T+4,
        // T+6 and T+8.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq($sformatf("cont_ack0_c%0d", k), {63'd0, ack0}, {63'd0, (k == 2 || k == 6)});
            check_eq($sformatf("cont_ack1_c%0d", k), {63'd0, ack1}, {63'd0, (k == 4 || k == 8)});
            if (k == 1) check_eq("cont_serve1_addr", mem_access_addr, 64'd5);
            if (k == 3) check_eq("cont_serve2_addr", mem_access_addr, 64'd7);
            if (k == 2) check_eq("cont_rdata0", rdata0, 64'hDEAD_BEEF);
            if (k == 4) check_eq("cont_rdata1", rdata1, 64'hCAFE);
            if (k == 6) req0 = 1'b0;
            if (k == 8) req1 = 1'b0;
            if (k == 9) check_eq("cont_end_state", 64'(dut_state), 64'(IDLE));
            @(posedge clk); #1;
        end

        // Single read, then write and read back on port 1.
        access(1'b0, 1'b0, 64'd5,  64'd0,    64'hDEAD_BEEF, 1'b0, "rd0_a5");
        access(1'b1, 1'b1, 64'd10, 64'h1234, 64'd0,         1'b0, "wr1_a10");
        access(1'b1, 1'b0, 64'd10, 64'd0,    64'h1234,      1'b0, "rd1_a10");
        check_eq("rdata0_hold", rdata0, 64'hDEAD_BEEF);

        // Out-of-range accesses and the range boundary.
        access(1'b0, 1'b1, 64'd256, 64'hFFFF, 64'd0, 1'b1, "wr0_oor");
        access(1'b0, 1'b0, 64'd0,   64'd0,    64'h0A0A, 1'b0, "rd0_a0_intact");
        access(1'b0, 1'b0, 64'd255, 64'd0,    64'h55, 1'b0, "rd0_a255");
        access(1'b1, 1'b0, 64'h8000_0000_0000_0005, 64'd0, 64'd0, 1'b1, "rd1_hi_oor");

        // Reset during SERVE of a port-1 read.
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'd5;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rstmid_serve_rd", {63'd0, mem_read}, 64'd1);
        rst = 1'b1;
        req1 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rstmid_ack", {62'd0, ack0, ack1}, 64'd0);
        check_eq("rstmid_rdata0", rdata0, 64'd0);
        check_eq("rstmid_rdata1", rdata1, 64'd0);
        check_eq("rstmid_err", {62'd0, err0, err1}, 64'd0);
        check_eq("rstmid_mem", {mem_access_addr[61:0], mem_write_en, mem_read}, 64'd0);
        check_eq("rstmid_state", 64'(dut_state), 64'(IDLE));
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'd7;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'd5;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rstmid_grant_addr", mem_access_addr, 64'd7);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rstmid_ack0", {63'd0, ack0}, 64'd1);
        check_eq("rstmid_ack1", {63'd0, ack1}, 64'd0);
        check_eq("rstmid_rdata0_cafe", rdata0, 64'hCAFE);
        req0 = 1'b0; req1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
